// File: rtl/rfphoenix_mem_arbiter_pkg.sv
// ============================================================================
// Module  : rfphoenix_mem_arbiter_pkg
// Brief   : Memory request/response types and arbiter constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rfphoenix_mem_arbiter_pkg;

    localparam int MEMARB_SRC_MSB  = 7;
    localparam int MEMARB_SEQ_BITS = 5;
    localparam int MEMARB_SRC_BITS = 8 - MEMARB_SEQ_BITS;

    typedef enum logic [2:0] {
        byt   = 3'd0,
        wyde  = 3'd1,
        tetra = 3'd2,
        octa  = 3'd3,
        hexi  = 3'd4,
        vect  = 3'd5
    } memsz_t;

    typedef struct packed {
        logic        v;
        logic [7:0]  tid;
        logic        wr;
        memsz_t      sz;
        logic [4:0]  step;
        logic [4:0]  count;
        logic [31:0] adr;
        logic [31:0] dat;
    } MemoryRequest;

    typedef struct packed {
        logic        v;
        logic [7:0]  tid;
        logic        err;
        logic [31:0] dat;
    } MemoryResponse;

    localparam int MEMARB_REQ_W  = $bits(MemoryRequest);
    localparam int MEMARB_RESP_W = $bits(MemoryResponse);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } memarb_state_t;

    // Transaction id: source index in the top bits, per-source sequence below.
    function automatic logic [7:0] memarb_tid(
        input logic [MEMARB_SRC_BITS-1:0] src,
        input logic [MEMARB_SEQ_BITS-1:0] seq
    );
        return {src, seq};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rfphoenix_rr_pick.sv
// ============================================================================
// Module  : rfphoenix_rr_pick
// Brief   : Round-robin first-one finder; searches upward from i_rr modulo NREQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 3
) (
    input  logic [NREQ-1:0]  i_eligible,
    input  logic [IDX_W-1:0] i_rr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotating the doubled mask puts source i_rr at bit 0 (i_rr < NREQ always).
    assign w_rot = NREQ'({i_eligible, i_eligible} >> i_rr);

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_rr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NREQ))
                                                 : w_sum[IDX_W-1:0];
    assign o_found = |i_eligible;
    assign o_grant = o_found ? (NREQ'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/rfphoenix_mem_arbiter.sv
// ============================================================================
// Module  : rfphoenix_mem_arbiter
// Brief   : Round-robin memory request arbiter with tid stamping, response
//           steering and per-source outstanding caps. Optional vector lock:
//           RFPHOENIX_MEMARB_VECLOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_mem_arbiter
    import rfphoenix_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int MAXOUT = 7
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ*MEMARB_REQ_W-1:0]  req_i,
    input  logic [NREQ-1:0]               req_v_i,
    output logic [NREQ-1:0]               req_rdy_o,
    output logic [MEMARB_REQ_W-1:0]       mreq_o,
    input  logic                          mreq_rdy_i,
    input  logic [MEMARB_RESP_W-1:0]      resp_i,
    output logic [NREQ-1:0]               resp_v_o,
    output logic [MEMARB_RESP_W-1:0]      resp_o,
    output logic                          busy_o
);

    localparam int CNT_W = 5;
    localparam int SRC_W = MEMARB_SRC_BITS;
    localparam logic [CNT_W-1:0] c_maxout = CNT_W'(MAXOUT);

    MemoryRequest                r_mreq;
    MemoryResponse               r_resp;
    MemoryResponse               w_resp;
    logic [NREQ-1:0]             r_resp_v;
    logic [SRC_W-1:0]            r_rr;
    logic [SRC_W-1:0]            w_resp_src;

    logic [NREQ-1:0]             w_elig_raw;
    logic [NREQ-1:0]             w_elig;
    logic [NREQ-1:0]             w_lock_mask;
    logic [NREQ-1:0]             w_gnt_oh;
    logic [NREQ-1:0]             w_dec;
    logic [NREQ-1:0]             w_cnt_nz;
    logic [SRC_W-1:0]            w_gnt_idx;
    logic                        w_gnt_any;
    logic                        w_slot_free;
    logic                        w_grant;
    logic                        w_rr_adv;
    MemoryRequest                w_sel;
    logic [MEMARB_SEQ_BITS-1:0]  w_sel_seq;
    logic [MEMARB_SEQ_BITS-1:0]  w_seq [NREQ];

    assign w_resp      = MemoryResponse'(resp_i);
    assign w_resp_src  = w_resp.tid[MEMARB_SRC_MSB -: SRC_W];
    assign w_slot_free = !r_mreq.v || mreq_rdy_i;
    assign w_elig      = w_elig_raw & w_lock_mask;
    assign w_grant     = w_slot_free && w_gnt_any;
    assign req_rdy_o   = w_grant ? w_gnt_oh : '0;

    rfphoenix_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .i_eligible (w_elig),
        .i_rr       (r_rr),
        .o_grant    (w_gnt_oh),
        .o_idx      (w_gnt_idx),
        .o_found    (w_gnt_any)
    );

    // Per-source outstanding counter and sequence number.
    for (genvar i = 0; i < NREQ; i++) begin : g_src
        logic [CNT_W-1:0]           r_cnt;
        logic [MEMARB_SEQ_BITS-1:0] r_seq;
        logic                       w_inc;

        assign w_inc         = w_grant && w_gnt_oh[i];
        assign w_dec[i]      = w_resp.v && (w_resp_src == SRC_W'(i));
        assign w_elig_raw[i] = req_v_i[i] && (r_cnt < c_maxout);
        assign w_cnt_nz[i]   = (r_cnt != '0);
        assign w_seq[i]      = r_seq;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt <= '0;
                r_seq <= '0;
            end else begin
                if (w_inc && !w_dec[i]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (!w_inc && w_dec[i] && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                if (w_inc) begin
                    r_seq <= r_seq + MEMARB_SEQ_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        w_sel     = '0;
        w_sel_seq = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel     = MemoryRequest'(req_i[i*MEMARB_REQ_W +: MEMARB_REQ_W]);
                w_sel_seq = w_seq[i];
            end
        end
    end

`ifdef RFPHOENIX_MEMARB_VECLOCK_EN
    memarb_state_t    r_state;
    memarb_state_t    w_state_nxt;
    logic [SRC_W-1:0] r_lock;
    logic [SRC_W-1:0] w_lock_nxt;

    assign w_lock_mask = (r_state == HOLD) ? (NREQ'(1) << r_lock) : '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB;
            r_lock  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // rr stays put from the locking grant until the releasing beat.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock;
        w_rr_adv    = w_grant;
        case (r_state)
            ARB: begin
                if (w_grant && (w_sel.sz == vect) && (w_sel.step != w_sel.count)) begin
                    w_state_nxt = HOLD;
                    w_lock_nxt  = w_gnt_idx;
                    w_rr_adv    = 1'b0;
                end
            end
            HOLD: begin
                w_rr_adv = 1'b0;
                if (w_grant && (w_sel.step == w_sel.count)) begin
                    w_state_nxt = ARB;
                    w_rr_adv    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end
`else
    assign w_lock_mask = '1;
    assign w_rr_adv    = w_grant;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mreq <= '0;
            r_rr   <= '0;
        end else begin
            if (w_grant) begin
                r_mreq     <= w_sel;
                r_mreq.v   <= 1'b1;
                r_mreq.tid <= memarb_tid(w_gnt_idx, w_sel_seq);
            end else if (w_slot_free) begin
                r_mreq.v <= 1'b0;
            end
            if (w_rr_adv) begin
                r_rr <= (w_gnt_idx == SRC_W'(NREQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
            end
        end
    end

    // Ids outside 0..NREQ-1 match no w_dec bit, so they are dropped here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp   <= '0;
            r_resp_v <= '0;
        end else begin
            r_resp   <= w_resp;
            r_resp_v <= w_dec;
        end
    end

    assign mreq_o   = r_mreq;
    assign resp_o   = r_resp;
    assign resp_v_o = r_resp_v;
    assign busy_o   = r_mreq.v || (|w_cnt_nz);

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_mem_arbiter.sv
// ============================================================================
// Module  : tb_rfphoenix_mem_arbiter
// Brief   : Self-checking bench for rfphoenix_mem_arbiter with reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfphoenix_mem_arbiter;
    import rfphoenix_mem_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int MAXOUT = 7;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    MemoryRequest                 req_a [NREQ];
    logic [NREQ*MEMARB_REQ_W-1:0] req_flat;
    logic [NREQ-1:0]              req_v;
    logic [NREQ-1:0]              rdy;
    logic [MEMARB_REQ_W-1:0]      mreq_raw;
    MemoryRequest                 mreq;
    logic                         mreq_rdy;
    MemoryResponse                resp_in;
    logic [NREQ-1:0]              resp_v;
    logic [MEMARB_RESP_W-1:0]     resp_out;
    logic                         busy;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_flat[i*MEMARB_REQ_W +: MEMARB_REQ_W] = req_a[i];
        end
    end
    assign mreq = MemoryRequest'(mreq_raw);

    rfphoenix_mem_arbiter #(.NREQ(NREQ), .MAXOUT(MAXOUT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req_flat),
        .req_v_i    (req_v),
        .req_rdy_o  (rdy),
        .mreq_o     (mreq_raw),
        .mreq_rdy_i (mreq_rdy),
        .resp_i     (resp_in),
        .resp_v_o   (resp_v),
        .resp_o     (resp_out),
        .busy_o     (busy)
    );

    // Reference model state
    MemoryRequest    m_mreq;
    MemoryResponse   m_resp;
    logic [NREQ-1:0] m_resp_v;
    int              m_cnt [NREQ];
    int              m_seq [NREQ];
    int              m_rr;
    bit              m_hold;
    int              m_lock;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              last_g;
    logic [NREQ-1:0] last_rdy;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mreq   = '0;
        m_resp   = '0;
        m_resp_v = '0;
        m_rr     = 0;
        m_hold   = 0;
        m_lock   = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_cnt[i] = 0;
            m_seq[i] = 0;
        end
    endtask

    function automatic int model_pick();
        int s;
        if (m_mreq.v && !mreq_rdy) return -1;
        for (int k = 0; k < NREQ; k++) begin
            s = (m_rr + k) % NREQ;
            if (req_v[s] && m_cnt[s] < MAXOUT && (!m_hold || s == m_lock)) return s;
        end
        return -1;
    endfunction

    // Compare DUT against the model, advance the model, and cross one clock edge.
    task automatic cycle();
        int              g;
        int              src;
        bit              inc, dec, busy_e;
        MemoryRequest    nr;
        logic [NREQ-1:0] exp_rdy;
        #1;
        g       = model_pick();
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        busy_e  = m_mreq.v;
        for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) busy_e = 1;
        check("req_rdy", rdy, exp_rdy);
        check("mreq_v", mreq.v, m_mreq.v);
        if (m_mreq.v) check("mreq", mreq_raw, m_mreq);
        check("resp_v", resp_v, m_resp_v);
        check("resp", resp_out, m_resp);
        check("busy", busy, busy_e);
        last_g   = g;
        last_rdy = rdy;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_mreq.v || mreq_rdy) begin
                if (g >= 0) begin
                    nr     = req_a[g];
                    nr.v   = 1'b1;
                    nr.tid = {3'(g), 5'(m_seq[g])};
                    m_mreq = nr;
                end else begin
                    m_mreq.v = 1'b0;
                end
            end
            src = int'(resp_in.tid[7:5]);
            for (int s = 0; s < NREQ; s++) begin
                inc = (g == s);
                dec = resp_in.v && (src == s);
                if (inc && !dec) m_cnt[s]++;
                else if (!inc && dec && m_cnt[s] > 0) m_cnt[s]--;
            end
            if (g >= 0) begin
                m_seq[g] = (m_seq[g] + 1) % 32;
`ifdef RFPHOENIX_MEMARB_VECLOCK_EN
                if (!m_hold) begin
                    if (req_a[g].sz == vect && req_a[g].step != req_a[g].count) begin
                        m_hold = 1;
                        m_lock = g;
                    end else begin
                        m_rr = (g + 1) % NREQ;
                    end
                end else if (req_a[g].step == req_a[g].count) begin
                    m_hold = 0;
                    m_rr   = (g + 1) % NREQ;
                end
`else
                m_rr = (g + 1) % NREQ;
`endif
            end
            m_resp   = resp_in;
            m_resp_v = (resp_in.v && src < NREQ) ? (NREQ'(1) << src) : '0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic MemoryRequest mkreq();
        MemoryRequest r;
        r       = '0;
        r.wr    = 1'($urandom_range(0, 1));
        r.sz    = memsz_t'($urandom_range(0, 3));
        r.adr   = $urandom();
        r.dat   = $urandom();
        return r;
    endfunction

    task automatic idle_inputs();
        req_v    = '0;
        mreq_rdy = 1'b1;
        resp_in  = '0;
        for (int i = 0; i < NREQ; i++) req_a[i] = mkreq();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [7:0]      tid_lit [5];
    int              ord_lit [5];
    logic [MEMARB_REQ_W-1:0] held;
    logic [31:0]     new_adr;

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;

        // Reset state
        check("rst_mreq_v", mreq.v, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_v", resp_v, '0);
        check("rst_resp", resp_out, '0);

        // All sources requesting: strict rotation and tid stamping
        tid_lit = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h01};
        ord_lit = '{0, 1, 2, 3, 0};
        req_v = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_order", 32'(last_g), 32'(ord_lit[k]));
            check("rr_tid", mreq.tid, tid_lit[k]);
        end

        // Outstanding cap on source 1
        idle_inputs();
        do_reset();
        req_v = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            cycle();
            check("cap_grant", last_rdy, 4'b0010);
        end
        cycle();
        check("cap_block", last_rdy, 4'b0000);
        resp_in = '{v: 1'b1, tid: 8'h23, err: 1'b0, dat: 32'h1234};
        cycle();
        check("cap_resp_cycle", last_rdy, 4'b0000);
        resp_in = '0;
        cycle();
        check("cap_reenable", last_rdy, 4'b0010);
        check("cap_resp_route", resp_v, 4'b0000);
        cycle();
        check("cap_full_again", last_rdy, 4'b0000);

        // Stall with source 2 waiting
        idle_inputs();
        do_reset();
        req_v = 4'b0100;
        cycle();
        held     = mreq_raw;
        mreq_rdy = 1'b0;
        new_adr  = 32'hCAFE_0042;
        req_a[2].adr = new_adr;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_rdy", last_rdy, 4'b0000);
            check("stall_hold", mreq_raw, held);
        end
        mreq_rdy = 1'b1;
        cycle();
        check("stall_release", last_rdy, 4'b0100);
        check("stall_new_tid", mreq.tid, 8'h41);
        check("stall_new_adr", mreq.adr, new_adr);

        // Same-cycle grant+response, bad ids, response to idle source
        idle_inputs();
        do_reset();
        req_v = 4'b0001;
        cycle();
        resp_in = '{v: 1'b1, tid: 8'h00, err: 1'b0, dat: 32'h5};
        cycle();
        req_v   = '0;
        resp_in = '0;
        cycle();
        cycle();
        check("same_cycle_busy", busy, 1'b1);
        resp_in = '{v: 1'b1, tid: 8'h00, err: 1'b0, dat: 32'h6};
        cycle();
        check("resp_route0", resp_v, 4'b0001);
        check("busy_clear", busy, 1'b0);
        resp_in = '{v: 1'b1, tid: 8'hE0, err: 1'b1, dat: 32'h7};
        cycle();
        check("bad_id_drop", resp_v, 4'b0000);
        resp_in = '{v: 1'b1, tid: 8'h20, err: 1'b0, dat: 32'h8};
        cycle();
        check("zero_cnt_route", resp_v, 4'b0010);
        check("zero_cnt_busy", busy, 1'b0);

        // Sequence wrap on source 3
        idle_inputs();
        do_reset();
        req_v   = 4'b1000;
        resp_in = '{v: 1'b1, tid: 8'h60, err: 1'b0, dat: 32'h0};
        for (int k = 0; k < 31; k++) cycle();
        cycle();
        check("wrap_31", mreq.tid, 8'h7F);
        cycle();
        check("wrap_0", mreq.tid, 8'h60);

        // Vector lock (or plain alternation when the lock is compiled out)
        idle_inputs();
        do_reset();
        req_v = 4'b0110;
`ifdef RFPHOENIX_MEMARB_VECLOCK_EN
        req_a[1].sz    = vect;
        req_a[1].count = 5'd3;
        req_a[1].step  = 5'd0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("vlock_src1", 32'(last_g), 32'd1);
            check("vlock_rdy", last_rdy, 4'b0010);
            req_a[1].step = req_a[1].step + 5'd1;
        end
        req_v = 4'b0100;
        cycle();
        check("vlock_release", last_rdy, 4'b0100);
`else
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("alt_rdy", last_rdy, (k % 2 == 0) ? 4'b0010 : 4'b0100);
        end
`endif

        // Randomized traffic
        idle_inputs();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 499) == 0);
            mreq_rdy = ($urandom_range(0, 3) != 0);
            req_v    = NREQ'($urandom());
            if (last_g >= 0) begin
`ifdef RFPHOENIX_MEMARB_VECLOCK_EN
                if (req_a[last_g].sz == vect && req_a[last_g].step < req_a[last_g].count) begin
                    req_a[last_g].step = req_a[last_g].step + 5'd1;
                end else begin
                    req_a[last_g] = mkreq();
                    if ($urandom_range(0, 3) == 0) begin
                        req_a[last_g].sz    = vect;
                        req_a[last_g].count = 5'($urandom_range(0, 3));
                    end
                end
`else
                req_a[last_g] = mkreq();
`endif
            end
            if ($urandom_range(0, 1) == 1) begin
                resp_in.v   = 1'b1;
                resp_in.tid = {3'($urandom_range(0, 5) == 5 ? 7 : $urandom_range(0, NREQ)),
                               5'($urandom())};
                resp_in.err = 1'($urandom());
                resp_in.dat = $urandom();
            end else begin
                resp_in = '0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rfphoenix_mem_arbiter.md
Name: rfphoenix_mem_arbiter

Overview:
- Shares the single memory-pipeline request port between NREQ requesters: I-cache loader, per-lane load/store unit and TLB walker.
- Selects one request per cycle by round-robin and stamps a transaction id into MemoryRequest.tid.
- Registers the selected request toward the memory pipeline.
- Routes each MemoryResponse back to its originating requester by tid, and caps the outstanding transactions per requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXOUT, 7, max outstanding transactions per requester (1..31).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NREQ x $bits(MemoryRequest)  request per requester.
- req_v_i  in  NREQ  request valid per requester.
- req_rdy_o  out  NREQ  request accepted this cycle (combinational, one-hot or zero).
- mreq_o  out  $bits(MemoryRequest)  registered request to the memory pipeline; mreq_o.v is the valid.
- mreq_rdy_i  in  1  memory pipeline accepts mreq_o this cycle.
- resp_i  in  $bits(MemoryResponse)  response from the memory pipeline; resp_i.v is the valid.
- resp_v_o  out  NREQ  response-valid steering, one-hot, registered.
- resp_o  out  $bits(MemoryResponse)  registered copy of resp_i.
- busy_o  out  1  any outstanding count non-zero or mreq_o.v set.

Behaviour:
- Reset: mreq_o = 0 (v=0), resp_v_o = 0, resp_o = 0, busy_o = 0, rr pointer = 0, all sequence counters = 0, all outstanding counters = 0, FSM = ARB.
- Eligibility: source i is eligible when req_v_i[i] = 1 and out_cnt[i] < MAXOUT.
- Slot free: the output slot is free when mreq_o.v = 0, or mreq_rdy_i = 1 in the same cycle.
- Grant: when the slot is free, pick the first eligible source searching from rr upward, modulo NREQ.
  - req_rdy_o[g] = 1 for that cycle.
  - mreq_o loads req_i[g] at the next edge with v=1 and tid = {g[2:0], seq[g][4:0]}.
  - seq[g] increments, wrapping 31 -> 0.
  - rr becomes g+1 mod NREQ.
- Latency: a request accepted at cycle N is on mreq_o at N+1.
- Stall: mreq_o holds stable while mreq_o.v = 1 and mreq_rdy_i = 0.
- Drain: if mreq_rdy_i = 1 and nothing is eligible, mreq_o.v clears next cycle.
- Counting: out_cnt[g] increments on grant and decrements on a response with resp_i.v=1 and resp_i.tid[7:5]=g. Grant and response to the same source in one cycle leave it unchanged.
- Response to an id >= NREQ: dropped; no resp_v_o bit, no counter change.
- Response to a source whose out_cnt = 0: routed anyway, counter saturates at 0.
- Response path: resp_o <= resp_i each cycle; resp_v_o <= one-hot(resp_i.tid[7:5]) when resp_i.v, otherwise 0. Latency 1. Responses are never backpressured.
- FSM (two states):
  - ARB: normal operation as above.
  - HOLD: used only with the optional feature. Grant is fixed to the locked source; other sources see req_rdy_o = 0.
- Reset mid-operation: all state cleared; in-flight responses arriving after reset are dropped only if they violate the id rule above, otherwise routed.

Optional Feature:
- Macro: RFPHOENIX_MEMARB_VECLOCK_EN.
- When defined:
  - A granted request with sz == vect and step != count moves the FSM to HOLD on that source.
  - In HOLD, the next grant may go only to that source.
  - Accepting a beat of that source with step == count returns the FSM to ARB.
  - rr is not advanced until the lock releases.
- When undefined: the HOLD state is absent and every grant is pure round-robin.

Decomposition:
- Shared package (extend rfPhoenixPkg): MemoryRequest, MemoryResponse, memsz_t; new constants MEMARB_SRC_MSB = 7 and MEMARB_SEQ_BITS = 5.
- One sub-module: rfphoenix_rr_pick (NREQ-wide round-robin first-one finder: inputs eligible mask and rr pointer, outputs one-hot grant and index).
- Counters and FSM stay in the top.

Test Plan:
- All four sources asserting req_v_i, mreq_rdy_i = 1 -> grants in order 0,1,2,3,0; tids 0x00, 0x20, 0x40, 0x60, 0x01; one grant per cycle.
- Source 1 issues 7 requests with no responses, MAXOUT = 7 -> 8th request is not granted. A response with tid 0x23 re-enables it next cycle, and out_cnt[1] returns to 7 after the grant.
- mreq_rdy_i held 0 for 5 cycles with source 2 valid -> mreq_o is unchanged, req_rdy_o = 0 throughout. Release -> source 2 is granted the same cycle and the new request appears on mreq_o the next cycle.
- Source 0: grant and response in the same cycle -> out_cnt[0] unchanged. Response tid 0xE0 with NREQ = 4 -> resp_v_o = 0.
- Source 3 seq reaching 31 -> next tid is 0x7F, the one after is 0x60 (wrap).
- With RFPHOENIX_MEMARB_VECLOCK_EN: source 1 vector request, count = 3, step 0..3, source 2 also valid -> four consecutive source-1 grants, then source 2 is granted.
